// File: rtl/uart_alu_packet_parser.sv
// UART ALU byte-stream packet parser: decodes the 4-byte header, forwards
// echo payloads and assembles little-endian 32-bit operands for the ALU.
module uart_alu_packet_parser #(
  parameter logic [7:0] OpEcho = 8'hEC,
  parameter logic [7:0] OpAdd  = 8'hAD,
  parameter logic [7:0] OpMul  = 8'h88,
  parameter logic [7:0] OpDiv  = 8'h99
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [7:0]  echo_data_o,
  output logic        echo_valid_o,
  input  logic        echo_ready_i,
  output logic [31:0] operand_o,
  output logic [7:0]  operand_op_o,
  output logic        operand_first_o,
  output logic        operand_last_o,
  output logic        operand_valid_o,
  input  logic        operand_ready_i,
  output logic        error_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_OPCODE,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_ECHO,
    S_OPERAND,
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q;
  logic [7:0]  len_lo_q;
  logic [15:0] rem_q;
  logic [23:0] sh_q;
  logic [1:0]  cnt_q;
  logic        first_q;

  logic        byte_fire;
  logic        hdr_err;
  logic [15:0] len;
  logic [15:0] rem_hdr;
  logic        short_len;
  logic        is_arith;
  logic        arith_ok;
  logic        echo_load;
  logic        op_load;

  assign byte_fire = byte_valid_i && byte_ready_o;
  assign len       = {byte_i, len_lo_q};
  assign rem_hdr   = len - 16'd4;
  assign short_len = len < 16'd4;
  assign is_arith  = (op_q == OpAdd) || (op_q == OpMul) || (op_q == OpDiv);
  assign arith_ok  = is_arith && (rem_hdr != 16'd0) && (rem_hdr[1:0] == 2'd0);
  assign echo_load = (state_q == S_ECHO) && byte_fire;
  assign op_load   = (state_q == S_OPERAND) && byte_fire && (cnt_q == 2'd3);
  assign busy_o    = state_q != S_OPCODE;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_OPCODE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    byte_ready_o = 1'b1;
    hdr_err      = 1'b0;
    unique case (state_q)
      S_OPCODE: if (byte_fire) state_d = S_RSVD;
      S_RSVD:   if (byte_fire) state_d = S_LEN_LO;
      S_LEN_LO: if (byte_fire) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (byte_fire) begin
          if (short_len) begin
            hdr_err = 1'b1;
            state_d = S_OPCODE;
          end else if (op_q == OpEcho) begin
            state_d = (rem_hdr == 16'd0) ? S_OPCODE : S_ECHO;
          end else if (arith_ok) begin
            state_d = S_OPERAND;
          end else begin
            hdr_err = 1'b1;
            state_d = (rem_hdr == 16'd0) ? S_OPCODE : S_DROP;
          end
        end
      end
      S_ECHO: begin
        byte_ready_o = !echo_valid_o || echo_ready_i;
        if (byte_fire && rem_q == 16'd1) state_d = S_OPCODE;
      end
      S_OPERAND: begin
        byte_ready_o = !operand_valid_o || operand_ready_i;
        if (byte_fire && rem_q == 16'd1) state_d = S_OPCODE;
      end
      S_DROP: if (byte_fire && rem_q == 16'd1) state_d = S_OPCODE;
      default: state_d = S_OPCODE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= '0;
      len_lo_q <= '0;
      rem_q    <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      error_o  <= 1'b0;
    end else begin
      error_o <= hdr_err;
      if (state_q == S_OPCODE && byte_fire) op_q <= byte_i;
      if (state_q == S_LEN_LO && byte_fire) len_lo_q <= byte_i;
      if (state_q == S_LEN_HI && byte_fire) begin
        rem_q   <= short_len ? 16'd0 : rem_hdr;
        cnt_q   <= 2'd0;
        first_q <= 1'b1;
      end
      if (byte_fire && (state_q == S_ECHO || state_q == S_OPERAND ||
                        state_q == S_DROP))
        rem_q <= rem_q - 16'd1;
      if (state_q == S_OPERAND && byte_fire) begin
        sh_q  <= {byte_i, sh_q[23:8]};
        cnt_q <= cnt_q + 2'd1;
      end
      if (op_load) first_q <= 1'b0;
    end
  end

  // Output registers: a load in the same cycle as a drain passes through
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      echo_data_o  <= '0;
      echo_valid_o <= 1'b0;
    end else if (echo_load) begin
      echo_data_o  <= byte_i;
      echo_valid_o <= 1'b1;
    end else if (echo_valid_o && echo_ready_i) begin
      echo_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      operand_o       <= '0;
      operand_op_o    <= '0;
      operand_first_o <= 1'b0;
      operand_last_o  <= 1'b0;
      operand_valid_o <= 1'b0;
    end else if (op_load) begin
      operand_o       <= {byte_i, sh_q};
      operand_op_o    <= op_q;
      operand_first_o <= first_q;
      operand_last_o  <= rem_q == 16'd1;
      operand_valid_o <= 1'b1;
    end else if (operand_valid_o && operand_ready_i) begin
      operand_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_alu_packet_parser.sv
// Scoreboard bench for the UART ALU packet parser: directed packets push
// expected outputs; a negedge monitor pops and compares on each transfer.
module tb_uart_alu_packet_parser;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] d;
    logic [7:0]  op;
    logic        f;
    logic        l;
  } opx_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic [7:0]  echo_data_o;
  logic        echo_valid_o;
  logic        echo_ready_i = 1'b1;
  logic [31:0] operand_o;
  logic [7:0]  operand_op_o;
  logic        operand_first_o;
  logic        operand_last_o;
  logic        operand_valid_o;
  logic        operand_ready_i = 1'b1;
  logic        error_o;
  logic        busy_o;

  uart_alu_packet_parser dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .byte_i(byte_i),
    .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o),
    .echo_data_o(echo_data_o),
    .echo_valid_o(echo_valid_o),
    .echo_ready_i(echo_ready_i),
    .operand_o(operand_o),
    .operand_op_o(operand_op_o),
    .operand_first_o(operand_first_o),
    .operand_last_o(operand_last_o),
    .operand_valid_o(operand_valid_o),
    .operand_ready_i(operand_ready_i),
    .error_o(error_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;
  int err_exp = 0;
  int cyc = 0;
  int last_echo = 0;
  int echo_gap = 0;
  logic [7:0] echo_q[$];
  opx_t op_q[$];

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  logic        err_prev = 1'b0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;
  logic        hold_f = 1'b0;
  logic        hold_l = 1'b0;

  always @(negedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      err_prev = 1'b0;
      hold_v = 1'b0;
    end else begin
      if (error_o) begin
        err_seen++;
        chk("error_width", {31'd0, err_prev}, 32'd0);
      end
      err_prev = error_o;
      if (echo_valid_o && echo_ready_i) begin
        if (echo_q.size() == 0) chk("echo_extra", {24'd0, echo_data_o}, 32'hFFFF);
        else begin
          chk("echo_data", {24'd0, echo_data_o}, {24'd0, echo_q.pop_front()});
          echo_gap = cyc - last_echo;
          last_echo = cyc;
        end
      end
      if (hold_v) begin
        chk("operand_hold", operand_o, hold_d);
        chk("operand_hold_fl", {30'd0, operand_first_o, operand_last_o},
            {30'd0, hold_f, hold_l});
      end
      hold_v = operand_valid_o && !operand_ready_i;
      hold_d = operand_o;
      hold_f = operand_first_o;
      hold_l = operand_last_o;
      if (operand_valid_o && operand_ready_i) begin
        if (op_q.size() == 0) chk("operand_extra", operand_o, 32'hDEAD_BEEF);
        else begin
          opx_t e;
          e = op_q.pop_front();
          chk("operand_data", operand_o, e.d);
          chk("operand_op", {24'd0, operand_op_o}, {24'd0, e.op});
          chk("operand_first", {31'd0, operand_first_o}, {31'd0, e.f});
          chk("operand_last", {31'd0, operand_last_o}, {31'd0, e.l});
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    byte_i = b;
    byte_valid_i = 1'b1;
    do begin
      @(negedge clk_i);
      t++;
    end while (!byte_ready_o && t < 200);
    if (!byte_ready_o) chk("byte_timeout", 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input bq_t p);
    foreach (p[i]) send(p[i]);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((echo_q.size() != 0 || op_q.size() != 0 || echo_valid_o ||
            operand_valid_o) && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    chk({nm, "_pending"}, echo_q.size() + op_q.size(), 32'd0);
    chk({nm, "_errors"}, err_seen, err_exp);
    chk({nm, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ready"}, {31'd0, byte_ready_o}, 32'd1);
    chk({nm, "_valids"}, {29'd0, echo_valid_o, operand_valid_o, error_o},
        32'd0);
    chk({nm, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({nm, "_operand"}, operand_o, 32'd0);
    chk({nm, "_misc"}, {14'd0, echo_data_o, operand_op_o,
        operand_first_o, operand_last_o}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_outs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // echo, full throughput
    echo_q.push_back(8'h42);
    echo_q.push_back(8'h69);
    send_pkt('{8'hEC, 8'h00, 8'h06, 8'h00, 8'h42, 8'h69});
    drain("echo");
    chk("echo_gap", echo_gap, 32'd1);

    // two-word add
    op_q.push_back('{32'h1, 8'hAD, 1'b1, 1'b0});
    op_q.push_back('{32'h2, 8'hAD, 1'b0, 1'b1});
    send_pkt('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
               8'h02, 8'h00, 8'h00, 8'h00});
    drain("add");

    // same add with the ALU stalled on the first word
    op_q.push_back('{32'h1, 8'hAD, 1'b1, 1'b0});
    op_q.push_back('{32'h2, 8'hAD, 1'b0, 1'b1});
    operand_ready_i = 1'b0;
    fork
      send_pkt('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                 8'h02, 8'h00, 8'h00, 8'h00});
      begin
        int t;
        t = 0;
        while (!operand_valid_o && t < 100) begin
          @(negedge clk_i);
          t++;
        end
        chk("stall_seen", {31'd0, operand_valid_o}, 32'd1);
        repeat (2) @(negedge clk_i);
        chk("stall_ready", {31'd0, byte_ready_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        operand_ready_i = 1'b1;
      end
    join
    drain("stall");

    // unknown opcode dropped, then echo
    err_exp++;
    echo_q.push_back(8'h7E);
    send_pkt('{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB});
    send_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E});
    drain("unknown");

    // bad lengths: ragged add, empty add, L below header size
    err_exp++;
    send_pkt('{8'hAD, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33});
    drain("add_l7");
    err_exp++;
    send_pkt('{8'hAD, 8'h00, 8'h04, 8'h00});
    drain("add_l4");
    err_exp++;
    send_pkt('{8'hEC, 8'h00, 8'h02, 8'h00});
    drain("echo_l2");

    // reset in the middle of an operand
    send_pkt('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00});
    rst_ni = 1'b0;
    #2;
    chk_reset_outs("midrst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    echo_q.push_back(8'h5A);
    send_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A});
    drain("post_rst_echo");
    op_q.push_back('{32'h3, 8'hAD, 1'b1, 1'b1});
    send_pkt('{8'hAD, 8'h00, 8'h08, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00});
    drain("post_rst_add");

    // mul and div, then echo under transmit backpressure
    op_q.push_back('{32'h1234_5678, 8'h88, 1'b1, 1'b1});
    send_pkt('{8'h88, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12});
    op_q.push_back('{32'hCAFE_0064, 8'h99, 1'b1, 1'b0});
    op_q.push_back('{32'h0000_0007, 8'h99, 1'b0, 1'b1});
    send_pkt('{8'h99, 8'h00, 8'h0C, 8'h00, 8'h64, 8'h00, 8'hFE, 8'hCA,
               8'h07, 8'h00, 8'h00, 8'h00});
    drain("muldiv");
    echo_q.push_back(8'hA1);
    echo_q.push_back(8'hA2);
    echo_q.push_back(8'hA3);
    echo_ready_i = 1'b0;
    fork
      send_pkt('{8'hEC, 8'h00, 8'h07, 8'h00, 8'hA1, 8'hA2, 8'hA3});
      begin
        repeat (8) @(posedge clk_i);
        #1;
        chk("echo_bp_hold", {24'd0, echo_data_o}, 32'hA1);
        echo_ready_i = 1'b1;
      end
    join
    drain("echo_bp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
